spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 143 ++++++++++++++
 tb/tb_spi_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one frame per request = command byte, address, data, MSB first.
// Latency: cs falls the cycle after handshake; rsp_valid (2*frame_bits+1)*CLK_DIV cycles later.
// Backpressure: req_ready only in IDLE; req_valid is ignored while a frame, hold or gap runs.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  localparam int FRAME = 8 + ADDR_W + DATA_W;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME - 1);
  localparam logic [BW-1:0] DATA_START = BW'(8 + ADDR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;       // clk cycles within the current half-period
  logic [BW-1:0]     bit_q, bit_d;       // index of the bit on the wire
  logic              hi_q, hi_d;         // 1 = high half of the current bit
  logic [FRAME-1:0]  sh_q, sh_d;         // outgoing frame, MSB is on mosi
  logic [DATA_W-1:0] rx_q, rx_d;         // incoming data-phase bits
  logic              wr_q, wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Next-state logic: half-period timing, bit sequencing, sampling and completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    hi_d        = hi_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    wr_d        = wr_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
          wr_d    = req_write;
          sh_d    = {req_write, 7'b0, req_addr, (req_write ? req_wdata : {DATA_W{1'b0}})};
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!hi_q) begin
            // End of low half: sclk rises now, so this is the sampling point
            hi_d = 1'b1;
            if (bit_q >= DATA_START) rx_d = {rx_q[DATA_W-2:0], miso};
          end else begin
            // End of high half: advance to the next bit, mosi changes with sclk low
            hi_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
              sh_d  = {sh_q[FRAME-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d       = '0;
          state_d     = GAP;
          rsp_valid_d = 1'b1;
          if (!wr_q) rdata_d = rx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      hi_q        <= 1'b0;
      sh_q        <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      hi_q        <= hi_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Pin outputs decode straight from registered state so reset forces them at once
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cs        = !((state_q == SHIFT) || (state_q == HOLD));
  assign sclk      = (state_q == SHIFT) && hi_q;
  assign mosi      = (state_q == SHIFT) && sh_q[FRAME-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=2) with mode-0 slave models.
// Latency: each transaction is checked at its rsp_valid pulse against a queued expectation.
// Backpressure: requests are held until req_ready is seen, then dropped.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready0, rsp_valid0, busy0, sclk0, mosi0, miso0, cs0;
  logic        req_ready1, rsp_valid1, busy1, sclk1, mosi1, miso1, cs1;
  logic [15:0] rsp_rdata0, rsp_rdata1;

  spi_master #(.CLK_DIV(4), .ADDR_W(16), .DATA_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs(cs0));

  spi_master #(.CLK_DIV(2), .ADDR_W(16), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs(cs1));

  // Slave models: load response at cs fall, capture mosi on rising sclk, shift miso on falling sclk
  logic [15:0] sdata = '0;
  logic [39:0] tx0 = '0, tx1 = '0, rx0 = '0, rx1 = '0;
  int bits0 = 0, bits1 = 0;
  int cslow0 = 0, cslow1 = 0, rspcnt0 = 0, rspcnt1 = 0, frames0 = 0;
  int gap0 = 0, last_gap0 = 0;
  assign miso0 = tx0[39];
  assign miso1 = tx1[39];

  always @(negedge cs0) begin tx0 = {24'h0, sdata}; rx0 = '0; bits0 = 0; cslow0 = 0; frames0++; last_gap0 = gap0; end
  always @(negedge cs1) begin tx1 = {24'h0, sdata}; rx1 = '0; bits1 = 0; cslow1 = 0; end
  always @(posedge cs0) gap0 = 0;
  always @(posedge sclk0) if (!cs0) begin rx0 = {rx0[38:0], mosi0}; bits0++; end
  always @(posedge sclk1) if (!cs1) begin rx1 = {rx1[38:0], mosi1}; bits1++; end
  always @(negedge sclk0) if (!cs0) tx0 = {tx0[38:0], 1'b0};
  always @(negedge sclk1) if (!cs1) tx1 = {tx1[38:0], 1'b0};
  always @(posedge clk) begin
    if (!cs0) cslow0++; else gap0++;
    if (!cs1) cslow1++;
    if (rsp_valid0) rspcnt0++;
    if (rsp_valid1) rspcnt1++;
  end

  // Observation mux so one set of tasks serves both instances
  logic sel = 1'b0;
  logic        obs_ready, obs_rsp;
  logic [15:0] obs_rdata;
  logic [39:0] obs_rx;
  int          obs_cslow;
  assign obs_ready = sel ? req_ready1 : req_ready0;
  assign obs_rsp   = sel ? rsp_valid1 : rsp_valid0;
  assign obs_rdata = sel ? rsp_rdata1 : rsp_rdata0;
  assign obs_rx    = sel ? rx1 : rx0;
  assign obs_cslow = sel ? cslow1 : cslow0;

  typedef struct {
    logic [39:0] frame;
    logic [15:0] rdata;
    int          cslen;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] model_rd [2];
  int cmp_cnt = 0, fail_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [15:0] a, input logic [15:0] wd, input logic [15:0] sd);
    exp_t e;
    int idx;
    idx     = sel ? 1 : 0;
    e.frame = {wr, 7'b0, a, (wr ? wd : 16'h0000)};
    if (!wr) model_rd[idx] = sd;
    e.rdata = model_rd[idx];
    e.cslen = 81 * (sel ? 2 : 4);
    sb.push_back(e);
  endtask

  task automatic set_req(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    req_write = wr; req_addr = a; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
  endtask

  // Waits for a handshake with req_valid already high; the next posedge takes it
  task automatic wait_hs();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (obs_ready) begin @(posedge clk); got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
  endtask

  task automatic wait_rsp();
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (obs_rsp) begin got = 1'b1; break; end
    end
    if (!got || sb.size() == 0) begin
      check("rsp_timeout", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("mosi_frame", 64'(obs_rx), 64'(e.frame));
      check("rsp_rdata", 64'(obs_rdata), 64'(e.rdata));
      check("cs_low_cycles", 64'(obs_cslow), 64'(e.cslen));
      @(negedge clk);
      check("rsp_one_cycle", 64'(obs_rsp), 64'd0);
    end
  endtask

  task automatic txn(input logic wr, input logic [15:0] a, input logic [15:0] wd, input logic [15:0] sd);
    sdata = sd;
    push_exp(wr, a, wd, sd);
    @(negedge clk);
    set_req(wr, a, wd);
    wait_hs();
    drop_valid();
    wait_rsp();
  endtask

  int r0, f0;

  initial begin
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_cs", 64'(cs0), 64'd1);
    check("rst_sclk", 64'(sclk0), 64'd0);
    check("rst_mosi", 64'(mosi0), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid0), 64'd0);
    check("rst_rdata", 64'(rsp_rdata0), 64'd0);
    check("rst_ready", 64'(req_ready0), 64'd1);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_cs_div2", 64'(cs1), 64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write and read on the CLK_DIV=4 instance
    sel = 1'b0;
    r0  = rspcnt0;
    txn(1'b1, 16'h0040, 16'h1234, 16'hFFFF);
    check("write_frame_literal", 64'(rx0), 64'h80_0040_1234);
    check("write_rsp_count", 64'(rspcnt0 - r0), 64'd1);
    txn(1'b0, 16'h0100, 16'h7777, 16'hA5C3);
    check("read_rdata_literal", 64'(rsp_rdata0), 64'hA5C3);

    // Boundary values
    txn(1'b1, 16'hFFFF, 16'hFFFF, 16'h0F0F);
    txn(1'b0, 16'h0000, 16'h0000, 16'hFFFF);
    txn(1'b0, 16'hFFFF, 16'hFFFF, 16'h0000);

    // req_valid held across a write then a read
    sel   = 1'b0;
    sdata = 16'h9696;
    r0    = rspcnt0;
    push_exp(1'b1, 16'h0AAA, 16'h5555, 16'h9696);
    push_exp(1'b0, 16'h0BBB, 16'h0000, 16'h9696);
    @(negedge clk);
    set_req(1'b1, 16'h0AAA, 16'h5555);
    wait_hs();
    @(negedge clk);
    set_req(1'b0, 16'h0BBB, 16'h0000);
    check("b2b_ready_low", 64'(req_ready0), 64'd0);
    check("b2b_busy", 64'(busy0), 64'd1);
    wait_rsp();
    wait_hs();
    drop_valid();
    check("b2b_gap_ge_div", 64'(last_gap0 >= 4), 64'd1);
    wait_rsp();
    check("b2b_rsp_count", 64'(rspcnt0 - r0), 64'd2);

    // req_valid pulsed mid-frame is ignored
    r0 = rspcnt0;
    f0 = frames0;
    sdata = 16'h0000;
    push_exp(1'b1, 16'h1111, 16'h2222, 16'h0000);
    @(negedge clk);
    set_req(1'b1, 16'h1111, 16'h2222);
    wait_hs();
    drop_valid();
    repeat (50) @(negedge clk);
    set_req(1'b0, 16'h3333, 16'h4444);
    repeat (3) @(negedge clk);
    req_valid0 = 1'b0;
    req_addr = 16'h1111; req_write = 1'b1; req_wdata = 16'h2222;
    wait_rsp();
    repeat (20) @(negedge clk);
    check("ignore_busy_idle", 64'(busy0), 64'd0);
    check("ignore_rsp_count", 64'(rspcnt0 - r0), 64'd1);
    check("ignore_frame_count", 64'(frames0 - f0), 64'd1);

    // Reset during bit 20 aborts the frame
    sdata = 16'h1357;
    r0    = rspcnt0;
    @(negedge clk);
    set_req(1'b0, 16'h0200, 16'h0000);
    wait_hs();
    drop_valid();
    for (int i = 0; i < 2000 && bits0 < 20; i++) @(negedge clk);
    check("abort_reached_bit20", 64'(bits0), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", 64'(cs0), 64'd1);
    check("abort_sclk", 64'(sclk0), 64'd0);
    check("abort_mosi", 64'(mosi0), 64'd0);
    check("abort_ready", 64'(req_ready0), 64'd1);
    check("abort_rdata", 64'(rsp_rdata0), 64'd0);
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_rsp", 64'(rspcnt0 - r0), 64'd0);
    txn(1'b0, 16'h0200, 16'h0000, 16'h2468);

    // CLK_DIV=2 instance
    sel = 1'b1;
    txn(1'b0, 16'h0042, 16'h0000, 16'h5A5A);
    txn(1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    check("div2_cs_low_162", 64'(cslow1), 64'd162);
    check("div2_rdata_zero", 64'(rsp_rdata1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
